// File: rtl/bft_stream_tx.sv
// Transmit leaf endpoint: packs 32-bit user beats into 49-bit BFT data packets
// for a fixed destination, gated by credits returned as freespace updates.
module bft_stream_tx #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 4,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter logic [NUM_LEAF_BITS-1:0] DST_LEAF  = 4'd3,
  parameter logic [NUM_PORT_BITS-1:0] DST_PORT  = 4'd2,
  parameter logic [NUM_PORT_BITS-1:0] SELF_PORT = 4'd1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  input  logic [PAYLOAD_BITS-1:0] din_user_TDATA,
  input  logic                    din_user_TVALID,
  output logic                    din_user_TREADY,
  output logic [7:0]              credit,
  output logic [31:0]             pkt_count
);

  localparam int VALID_BIT = PACKET_BITS - 1;
  localparam int TYPE_BIT  = PAYLOAD_BITS;
  localparam int ADDR_LSB  = PAYLOAD_BITS + 1;
  localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
  localparam logic [8:0] MAX_CREDIT = 9'(1 << NUM_ADDR_BITS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state_reg, state_next;
  logic [7:0]               credit_reg, credit_next;
  logic [NUM_ADDR_BITS-1:0] addr_reg, addr_next;
  logic [31:0]              pkt_count_reg, pkt_count_next;
  logic [PACKET_BITS-1:0]   dout_reg, dout_next;

  logic       tready;
  logic       handshake;
  logic       upd_hit;
  logic [7:0] upd_amount;
  logic [8:0] credit_sum;

  // Fields of incoming packets that play no part in credit return.
  logic unused_din;
  assign unused_din = ^{din_leaf_bft2interface[VALID_BIT-1:LEAF_LSB],
                        din_leaf_bft2interface[PORT_LSB-1:ADDR_LSB],
                        din_leaf_bft2interface[PAYLOAD_BITS-1:8]};

  // Ready depends only on registered state, never on TVALID.
  assign tready    = (state_reg == RUN) && (credit_reg != 8'd0);
  assign handshake = tready && din_user_TVALID;

  // Freespace update: valid, type=1, addressed to our port; leaf is not checked.
  assign upd_hit = din_leaf_bft2interface[VALID_BIT] &&
                   din_leaf_bft2interface[TYPE_BIT] &&
                   (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == SELF_PORT);
  assign upd_amount = upd_hit ? din_leaf_bft2interface[7:0] : 8'd0;

  // 9-bit sum cannot underflow: a send requires credit >= 1.
  assign credit_sum = {1'b0, credit_reg} + {1'b0, upd_amount} - {8'd0, handshake};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    credit_next    = (credit_sum > MAX_CREDIT) ? MAX_CREDIT[7:0] : credit_sum[7:0];
    addr_next      = addr_reg;
    pkt_count_next = pkt_count_reg;
    dout_next      = '0;
    if (handshake) begin
      dout_next      = {1'b1, DST_LEAF, DST_PORT, addr_reg, 1'b0, din_user_TDATA};
      addr_next      = addr_reg + 1'b1;
      pkt_count_next = pkt_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      credit_reg    <= MAX_CREDIT[7:0];
      addr_reg      <= '0;
      pkt_count_reg <= '0;
      dout_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      credit_reg    <= credit_next;
      addr_reg      <= addr_next;
      pkt_count_reg <= pkt_count_next;
      dout_reg      <= dout_next;
    end
  end

  assign dout_leaf_interface2bft = dout_reg;
  assign din_user_TREADY         = tready;
  assign credit                  = credit_reg;
  assign pkt_count               = pkt_count_reg;

endmodule

// File: doc/bft_stream_tx.md
Name: bft_stream_tx

Overview:
- Transmit-side leaf endpoint. Accepts a 32-bit AXI-stream-style user stream and packs each beat into a 49-bit BFT packet addressed to a fixed destination leaf and port.
- Enforces receiver-buffer flow control with a credit counter. The counter is replenished by freespace-update packets arriving on the BFT input.
- Sits between an HLS operator's Output stream and a leaf's BFT ports. It is the sending peer of the leaf receive interface.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 4, leaf-id field width.
- NUM_PORT_BITS, 4, port-id field width.
- NUM_ADDR_BITS, 7, receiver buffer address width; receiver depth = 2^NUM_ADDR_BITS = 128.
- DST_LEAF, 4'd3, destination leaf id placed in every data packet.
- DST_PORT, 4'd2, destination port id placed in every data packet.
- SELF_PORT, 4'd1, port id that incoming freespace updates must carry to be accepted.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level; enables transmission
- din_leaf_bft2interface  in  49  incoming BFT packets (credit returns)
- dout_leaf_interface2bft  out  49  outgoing BFT packets
- din_user_TDATA  in  32  user payload
- din_user_TVALID  in  1  user payload valid
- din_user_TREADY  out  1  block accepts beat
- credit  out  8  current credit count, 0..128
- pkt_count  out  32  data packets sent since reset

Behaviour:
- Packet format:
  - [48] valid
  - [47:44] leaf
  - [43:40] port
  - [39:33] addr
  - [32] type (0 = data, 1 = freespace update)
  - [31:0] payload
- Reset (async, reset_n=0):
  - state=IDLE, credit=128, addr=0, pkt_count=0.
  - dout=49'b0, din_user_TREADY=0.
  - Reset mid-packet aborts with no partial output; dout is 0 on the cycle following deassertion.
- FSM states:
  - IDLE: TREADY=0, no output. Goes to RUN on the first clock edge with start=1.
  - RUN: TREADY = (credit != 0). Returns to IDLE when start=0. Any beat handshaken on that same edge is still sent.
- Data path:
  - A handshake (TVALID && TREADY at the rising edge) registers dout = {1'b1, DST_LEAF, DST_PORT, addr, 1'b0, TDATA}.
  - Latency is 1 cycle; dout is valid for exactly one cycle per beat.
  - With no handshake, dout = 0 (bit 48 = 0). Back-to-back beats produce back-to-back packets.
  - addr increments by 1 per packet, modulo 128 (127 wraps to 0).
  - pkt_count increments per packet and wraps at 2^32.
- Credit return:
  - An incoming packet with [48]=1, [32]=1 and [43:40]=SELF_PORT is an update of amount payload[7:0].
  - Packets failing any of these checks are ignored. Leaf field is not checked.
- Credit arithmetic (per edge): credit_next = min(128, credit + upd − send), where upd = update amount or 0 and send = 1 if handshake else 0.
  - Computed in 9 bits before clamping.
  - A simultaneous update and send in the same cycle applies both.
  - An update of 0 is a no-op.
- Credit boundaries:
  - credit=0: TREADY=0, no packets emitted.
  - credit=1 with a handshake: credit goes to 0 and TREADY drops on the next cycle. No overshoot is permitted.
- TREADY is a registered-state function (depends on state and credit only), not combinational on TVALID.
- Update while in IDLE: credit is still updated.

Test Plan:
- Reset then start=1, 3 beats 0xA, 0xB, 0xC with TVALID held → dout on consecutive cycles = {1,3,2,addr0..2,0,data}; credit=125; pkt_count=3.
- Hold TVALID with no updates for 130 cycles → exactly 128 packets; TREADY=0 after the 128th; credit=0; addr wrapped to 0.
- At credit=0, inject update with port 1, type 1, payload 64 → TREADY=1 next cycle, credit=64. Same packet with port 5 → ignored, credit unchanged.
- At credit=10, update of 64 arrives on the same cycle as a handshake → credit=73. At credit=100, update of 64 → clamped to 128.
- Deassert start mid-burst → last accepted beat is still emitted, then TREADY=0 and state IDLE. Reassert → addr continues sequence.
- Assert reset_n=0 asynchronously mid-burst → dout, TREADY and pkt_count go to 0 immediately; credit=128, addr=0.
